axis_rr_arbiter: RTL and testbench
==================================

Name: axis_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares the write (s_axis) side of one axis_async_fifo between NUM_PORTS AXI-stream requesters.
- Sits in the write clock domain, directly upstream of the FIFO.
- Holds the grant from the first beat of a packet until its tlast beat is accepted, so packets never interleave.
- Tags each output beat with the source port index; the output is registered through a skid slice.

Parameters:
- NUM_PORTS, 4, number of requesting AXI-stream slaves (2..16)
- DWIDTH, 256, tdata width per port; tkeep width is DWIDTH/8
- IDW (localparam), CLOG2(NUM_PORTS) with a minimum of 1, width of the port index

Ports:
- clk  input  1  single clock (FIFO write clock)
- resetn  input  1  reset, asynchronous, active-low
- s_axis_tvalid  input  NUM_PORTS  per-port valid
- s_axis_tready  output  NUM_PORTS  per-port ready
- s_axis_tdata  input  NUM_PORTS*DWIDTH  port p occupies bits [p*DWIDTH +: DWIDTH]
- s_axis_tkeep  input  NUM_PORTS*DWIDTH/8  port p occupies bits [p*DWIDTH/8 +: DWIDTH/8]
- s_axis_tlast  input  NUM_PORTS  per-port end-of-packet
- m_axis_tvalid  output  1  to FIFO
- m_axis_tready  input  1  from FIFO (equals ~full)
- m_axis_tdata  output  DWIDTH  selected data
- m_axis_tkeep  output  DWIDTH/8  selected keep
- m_axis_tlast  output  1  selected last
- m_axis_tid  output  IDW  index of the port that sourced the beat

Behaviour:
- Reset values: state=IDLE, grant=0, ptr=0, slice empty, m_axis_tvalid=0, all s_axis_tready=0. Other m_axis outputs are 0.
- FSM has two states, IDLE and BUSY.
- IDLE arbitration:
  - Scan ports ptr, ptr+1, …, ptr+NUM_PORTS-1 (mod NUM_PORTS). The first with tvalid=1 wins.
  - The winner is registered into grant, and the state moves to BUSY on the next edge.
  - If no port is valid, stay in IDLE.
  - All s_axis_tready=0 while in IDLE.
- BUSY:
  - s_axis_tready[p] = (p==grant) & slice_in_ready. All other ports' ready=0.
  - Beats of port grant pass into the slice tagged tid=grant.
  - When a beat with tlast=1 handshakes on port grant: go to IDLE and set ptr <= (grant+1) mod NUM_PORTS.
  - Consequence: one idle cycle between packets, so the minimum inter-packet gap is 1 cycle.
- Fairness:
  - A port that just finished has the lowest priority on the next arbitration.
  - With all ports continuously valid, grants rotate 0,1,2,3,0…
- Grant ignores tvalid deassertion mid-packet: the arbiter stays in BUSY on the same port until that port's tlast.
- A single-beat packet (tlast on the first beat) returns to IDLE after exactly one BUSY cycle.
- Output slice (axis_skid_slice):
  - Two-entry register slice; slice_in_ready is registered (not combinationally dependent on m_axis_tready).
  - Latency 1 cycle from the s-side handshake to m_axis_tvalid.
  - Sustains 1 beat/cycle when m_axis_tready=1.
  - m_axis_* is stable while tvalid=1 and tready=0 (AXI rule).
  - Beat order is preserved.
- FIFO full (m_axis_tready=0):
  - The slice absorbs at most 2 beats, then slice_in_ready=0, which stalls the granted port.
  - The grant is held and no data is lost or duplicated.
- A port's tvalid rising in the same cycle that the current packet's tlast is accepted is considered in the next IDLE cycle.
- Reset asserted mid-packet:
  - All state clears immediately and the slice is flushed; a partial packet is dropped.
  - Upstream sources must also be reset, since the arbiter does not resynchronise to packet boundaries.
- NUM_PORTS=1: degenerates to a pass-through with a 1-cycle IDLE bubble per packet and tid=0.

Decomposition:
- Add a CLOG2 macro to common.vh if absent. Add FSM state encodings to common.vh as `define ARB_IDLE=1'b0 / ARB_BUSY=1'b1.
- Sub-module axis_skid_slice (parameter WIDTH = DWIDTH + DWIDTH/8 + 1 + IDW) carries the concatenated {tdata, tkeep, tlast, tid}.
  - It is reusable in front of axis_async_fifo elsewhere.
- The round-robin priority search is an always @(*) loop in the top module, not a separate module.

Test Plan:
- Reset/idle: hold resetn=0 for 5 cycles, then release with no valids → m_axis_tvalid=0, s_axis_tready=4'b0000, no grant.
- Rotation: all 4 ports continuously send 2-beat packets and m_axis_tready=1.
  - m_axis_tid sequence is 0,0,1,1,2,2,3,3,0…
  - Each packet is followed by exactly one bubble cycle, and data matches the per-port patterns.
- No interleave under contention: port 1 sends an 8-beat packet while port 0 asserts valid at beat 3.
  - The 8 port-1 beats are contiguous with tid=1, then the port-0 packet follows with tid=0.
  - s_axis_tready[0] stays 0 throughout the port-1 packet.
- Backpressure: hold m_axis_tready=0 for 10 cycles during a 6-beat packet from port 2.
  - Exactly 2 beats are accepted into the slice and s_axis_tready[2]=0 afterwards.
  - After release, all 6 beats arrive in order, with no duplicates and tkeep intact.
  - m_axis outputs stay stable while stalled.
- Single-beat packets: port 3 sends a single beat with tlast=1, keep=32'h0000_00FF.
  - m_axis_tvalid rises 1 cycle after the handshake, with tid=3 and tlast=1.
  - Next arbitration starts from ptr=0.
- Reset mid-packet: assert resetn=0 at beat 2 of a 5-beat port-0 packet.
  - m_axis_tvalid=0 and s_axis_tready=0 in the same cycle (asynchronous).
  - After release, a fresh port-1 packet is granted first-come, with ptr=0.

Source files
------------

// File: rtl/axis_rr_arbiter_pkg.sv
// rtl/axis_rr_arbiter_pkg.sv - shared types and index helpers for the packet arbiter
package axis_rr_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   // Port index width; a single-port build still carries a 1-bit tid.
   function automatic int arb_idw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/axis_skid_slice.sv
// rtl/axis_skid_slice.sv - two-entry stream register slice with a registered input ready
module axis_skid_slice #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   input  logic [WIDTH-1:0] s_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic [WIDTH-1:0] m_axis_tdata
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             in_ready_q, in_ready_d;
   logic             in_hs;

   assign in_hs = s_axis_tvalid & in_ready_q;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (!out_valid_q || m_axis_tready) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = in_hs;
            if (in_hs) begin
               out_data_d = s_axis_tdata;
            end
         end
      end else if (in_hs) begin
         // Output is stalled: park the beat that was already promised a slot.
         skid_valid_d = 1'b1;
         skid_data_d  = s_axis_tdata;
      end
      in_ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         in_ready_q   <= 1'b1;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign s_axis_tready = in_ready_q;
   assign m_axis_tvalid = out_valid_q;
   assign m_axis_tdata  = out_data_q;

endmodule

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - packet-level round-robin arbiter feeding the FIFO write side
module axis_rr_arbiter
   import axis_rr_arbiter_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int DWIDTH    = 256,
   localparam int IDW      = arb_idw(NUM_PORTS)
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
   output logic [NUM_PORTS-1:0]          s_axis_tready,
   input  logic [NUM_PORTS*DWIDTH-1:0]   s_axis_tdata,
   input  logic [NUM_PORTS*DWIDTH/8-1:0] s_axis_tkeep,
   input  logic [NUM_PORTS-1:0]          s_axis_tlast,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [DWIDTH-1:0]             m_axis_tdata,
   output logic [DWIDTH/8-1:0]           m_axis_tkeep,
   output logic                          m_axis_tlast,
   output logic [IDW-1:0]                m_axis_tid
);

   localparam int KW = DWIDTH / 8;
   localparam int SW = DWIDTH + KW + 1 + IDW;

   arb_state_e     state_q, state_d;
   logic [IDW-1:0] grant_q, grant_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic           found;
   int unsigned    idx;

   logic           sel_valid, sel_last;
   logic [DWIDTH-1:0] sel_data;
   logic [KW-1:0]  sel_keep;
   logic           slice_in_valid, slice_in_ready;
   logic [SW-1:0]  slice_in_data, slice_out_data;

   assign sel_valid = s_axis_tvalid[grant_q];
   assign sel_last  = s_axis_tlast[grant_q];
   assign sel_data  = s_axis_tdata[int'(grant_q)*DWIDTH +: DWIDTH];
   assign sel_keep  = s_axis_tkeep[int'(grant_q)*KW +: KW];

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      found   = 1'b0;
      idx     = 0;
      case (state_q)
         ARB_IDLE: begin
            // Scan starts at ptr so the port that just finished is considered last.
            for (int i = 0; i < NUM_PORTS; i++) begin
               idx = (int'(ptr_q) + i) % NUM_PORTS;
               if (!found && s_axis_tvalid[idx]) begin
                  found   = 1'b1;
                  grant_d = IDW'(idx);
               end
            end
            if (found) begin
               state_d = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (sel_valid && slice_in_ready && sel_last) begin
               state_d = ARB_IDLE;
               ptr_d   = IDW'(wrap_inc(int'(grant_q), NUM_PORTS));
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      s_axis_tready = '0;
      if (state_q == ARB_BUSY) begin
         s_axis_tready[grant_q] = slice_in_ready;
      end
   end

   assign slice_in_valid = (state_q == ARB_BUSY) && sel_valid;
   assign slice_in_data  = {sel_data, sel_keep, sel_last, grant_q};

   axis_skid_slice #(
      .WIDTH (SW)
   ) u_slice (
      .clk           (clk),
      .resetn        (resetn),
      .s_axis_tvalid (slice_in_valid),
      .s_axis_tready (slice_in_ready),
      .s_axis_tdata  (slice_in_data),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (slice_out_data)
   );

   assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid} = slice_out_data;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb/tb_axis_rr_arbiter.sv - self-checking bench for the packet round-robin arbiter
module tb_axis_rr_arbiter;

   localparam int NP  = 4;
   localparam int DW  = 256;
   localparam int KW  = DW / 8;
   localparam int IDW = 2;

   typedef struct {
      logic [DW-1:0]  d;
      logic [KW-1:0]  k;
      logic           l;
      logic [IDW-1:0] id;
   } beat_t;

   typedef struct {
      logic [NP-1:0] mask;
      int            exp_port;
   } vec_t;

   logic               clk, resetn;
   logic [NP-1:0]      s_tvalid, s_tready, s_tlast;
   logic [NP*DW-1:0]   s_tdata;
   logic [NP*KW-1:0]   s_tkeep;
   logic               m_tvalid, m_tready, m_tlast;
   logic [DW-1:0]      m_tdata;
   logic [KW-1:0]      m_tkeep;
   logic [IDW-1:0]     m_tid;

   logic               vld[NP];
   logic               lst[NP];
   logic [DW-1:0]      dat[NP];
   logic [KW-1:0]      kp[NP];

   beat_t sb[$];
   int    log_cyc[$];
   int    log_tid[$];
   int    log_last[$];
   int    hs_cnt[NP];
   int    cyc, last_s_cyc;
   int    n_checks, n_pass;
   logic  watch_tr0, tr0_seen;
   vec_t  vecs[10];

   axis_rr_arbiter #(
      .NUM_PORTS (NP),
      .DWIDTH    (DW)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tlast  (s_tlast),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tlast  (m_tlast),
      .m_axis_tid    (m_tid)
   );

   always_comb begin
      s_tvalid = '0;
      s_tlast  = '0;
      s_tdata  = '0;
      s_tkeep  = '0;
      for (int p = 0; p < NP; p++) begin
         s_tvalid[p]          = vld[p];
         s_tlast[p]           = lst[p];
         s_tdata[p*DW +: DW]  = dat[p];
         s_tkeep[p*KW +: KW]  = kp[p];
      end
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [DW-1:0] mk(input int p, input int tag, input int b);
      logic [31:0] w;
      w = {8'(p), 16'(tag), 8'(b)};
      return {8{w}};
   endfunction

   // Scoreboard: expectation pushed at each upstream handshake, popped at each downstream one.
   initial begin : monitor
      logic          prev_stall;
      logic [DW-1:0] pd;
      logic [KW-1:0] pk;
      logic          pl;
      logic [IDW-1:0] pid;
      int            nhs;
      beat_t         e;
      prev_stall = 1'b0;
      pd = '0; pk = '0; pl = 1'b0; pid = '0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            sb.delete();
            prev_stall = 1'b0;
         end else begin
            nhs = 0;
            for (int p = 0; p < NP; p++) begin
               if (s_tvalid[p] && s_tready[p]) begin
                  nhs++;
                  hs_cnt[p]++;
                  last_s_cyc = cyc;
                  sb.push_back('{d: dat[p], k: kp[p], l: lst[p], id: IDW'(p)});
               end
            end
            if (watch_tr0 && s_tready[0]) tr0_seen = 1'b1;
            if (nhs > 0) check("single_grant", nhs == 1, 32'(nhs), 32'd1);
            if (prev_stall)
               check("stall_stable", m_tvalid && m_tdata == pd && m_tkeep == pk && m_tlast == pl && m_tid == pid,
                     m_tdata[31:0], pd[31:0]);
            if (m_tvalid && m_tready) begin
               check("sb_nonempty", sb.size() > 0, 32'(sb.size()), 32'd1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  check("m_beat", m_tdata == e.d && m_tkeep == e.k && m_tlast == e.l && m_tid == e.id,
                        {m_tid, m_tlast, m_tdata[28:0]}, {e.id, e.l, e.d[28:0]});
               end
               log_cyc.push_back(cyc);
               log_tid.push_back(int'(m_tid));
               log_last.push_back(int'(m_tlast));
            end
            prev_stall = m_tvalid && !m_tready;
            pd = m_tdata; pk = m_tkeep; pl = m_tlast; pid = m_tid;
         end
      end
   end

   task automatic clear_ports();
      for (int p = 0; p < NP; p++) begin
         vld[p] = 1'b0;
         lst[p] = 1'b0;
      end
   endtask

   task automatic clear_logs();
      log_cyc.delete();
      log_tid.delete();
      log_last.delete();
      for (int p = 0; p < NP; p++) hs_cnt[p] = 0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      clear_ports();
      repeat (5) @(posedge clk);
      #1;
      resetn = 1'b1;
      clear_logs();
   endtask

   task automatic send_pkt(input int p, input int n, input int tag, input logic [KW-1:0] keep);
      logic done;
      for (int b = 0; b < n; b++) begin
         vld[p] = 1'b1;
         dat[p] = mk(p, tag, b);
         kp[p]  = keep;
         lst[p] = (b == n - 1);
         done   = 1'b0;
         for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            #1;
            if (!resetn) begin
               vld[p] = 1'b0;
               lst[p] = 1'b0;
               return;
            end
            if (s_tready[p]) done = 1'b1;
         end
         check("send_accept", done, 32'(done), 32'd1);
         if (!done) begin
            vld[p] = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      vld[p] = 1'b0;
      lst[p] = 1'b0;
   endtask

   task automatic arb_one(input logic [NP-1:0] mask, input int exp_port, input int tag);
      int win;
      for (int p = 0; p < NP; p++) begin
         vld[p] = mask[p];
         dat[p] = mk(p, tag, 0);
         kp[p]  = '1;
         lst[p] = 1'b1;
      end
      win = -1;
      for (int c = 0; c < 20 && win < 0; c++) begin
         @(negedge clk);
         #1;
         for (int p = 0; p < NP; p++)
            if (vld[p] && s_tready[p]) win = p;
      end
      @(posedge clk);
      #1;
      clear_ports();
      check("arb_grant", win == exp_port, 32'(win), 32'(exp_port));
   endtask

   task automatic drain();
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0 && !m_tvalid) break;
      end
      check("drain", sb.size() == 0 && !m_tvalid, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      n_checks = 0; n_pass = 0;
      watch_tr0 = 1'b0; tr0_seen = 1'b0;
      last_s_cyc = 0;
      for (int p = 0; p < NP; p++) begin
         dat[p] = '0; kp[p] = '0; hs_cnt[p] = 0;
      end
      clear_ports();
      m_tready = 1'b1;

      // Priority search vectors; pointer trail from reset: 0,1,2,1,0,2,1,3,2,0,(2)
      vecs[0] = '{4'b1111, 0};
      vecs[1] = '{4'b1111, 1};
      vecs[2] = '{4'b0001, 0};
      vecs[3] = '{4'b1001, 3};
      vecs[4] = '{4'b1010, 1};
      vecs[5] = '{4'b0011, 0};
      vecs[6] = '{4'b0100, 2};
      vecs[7] = '{4'b0110, 1};
      vecs[8] = '{4'b1000, 3};
      vecs[9] = '{4'b1110, 1};

      resetn = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_m_tvalid", m_tvalid == 1'b0, 32'(m_tvalid), 32'd0);
      check("rst_s_tready", s_tready == '0, 32'(s_tready), 32'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_m_tvalid", m_tvalid == 1'b0, 32'(m_tvalid), 32'd0);
      check("idle_s_tready", s_tready == '0, 32'(s_tready), 32'd0);
      check("idle_m_fields", m_tdata == '0 && m_tkeep == '0 && !m_tlast && m_tid == '0, m_tdata[31:0], 32'd0);

      for (int i = 0; i < 10; i++) begin
         arb_one(vecs[i].mask, vecs[i].exp_port, 100 + i);
         drain();
      end

      // Rotation with every port continuously offering 2-beat packets.
      do_reset();
      fork
         begin send_pkt(0, 2, 10, '1); send_pkt(0, 2, 11, '1); end
         begin send_pkt(1, 2, 12, '1); send_pkt(1, 2, 13, '1); end
         begin send_pkt(2, 2, 14, '1); send_pkt(2, 2, 15, '1); end
         begin send_pkt(3, 2, 16, '1); send_pkt(3, 2, 17, '1); end
      join
      drain();
      check("rot_count", log_tid.size() == 16, 32'(log_tid.size()), 32'd16);
      for (int i = 0; i < 16 && i < log_tid.size(); i++) begin
         check("rot_tid", log_tid[i] == (i / 2) % 4, 32'(log_tid[i]), 32'((i / 2) % 4));
         if (i > 0)
            check("rot_gap", log_cyc[i] - log_cyc[i-1] == ((i % 2 == 0) ? 2 : 1),
                  32'(log_cyc[i] - log_cyc[i-1]), 32'((i % 2 == 0) ? 2 : 1));
      end

      // No interleave: port 0 requests while port 1 is mid-packet.
      do_reset();
      tr0_seen = 1'b0;
      fork
         begin
            watch_tr0 = 1'b1;
            send_pkt(1, 8, 30, 32'h1234_5678);
            watch_tr0 = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            send_pkt(0, 2, 31, '1);
         end
      join
      drain();
      check("ni_tready0", tr0_seen == 1'b0, 32'(tr0_seen), 32'd0);
      check("ni_count", log_tid.size() == 10, 32'(log_tid.size()), 32'd10);
      for (int i = 0; i < 10 && i < log_tid.size(); i++) begin
         check("ni_tid", log_tid[i] == ((i < 8) ? 1 : 0), 32'(log_tid[i]), 32'((i < 8) ? 1 : 0));
         if (i > 0 && i < 8)
            check("ni_contig", log_cyc[i] - log_cyc[i-1] == 1, 32'(log_cyc[i] - log_cyc[i-1]), 32'd1);
      end

      // Backpressure: downstream full for 10 cycles during a 6-beat packet.
      do_reset();
      m_tready = 1'b0;
      fork
         send_pkt(2, 6, 40, 32'hA5A5_0F0F);
         begin
            repeat (10) @(posedge clk);
            @(negedge clk);
            #1;
            check("bp_accepted", hs_cnt[2] == 2, 32'(hs_cnt[2]), 32'd2);
            check("bp_ready_low", s_tready[2] == 1'b0, 32'(s_tready[2]), 32'd0);
            check("bp_out_held", m_tvalid == 1'b1, 32'(m_tvalid), 32'd1);
            @(posedge clk);
            #1;
            m_tready = 1'b1;
         end
      join
      drain();
      check("bp_count", log_tid.size() == 6, 32'(log_tid.size()), 32'd6);
      for (int i = 0; i < log_tid.size(); i++)
         check("bp_tid", log_tid[i] == 2, 32'(log_tid[i]), 32'd2);

      // Single-beat packet from port 3, then the pointer must have wrapped to 0.
      clear_logs();
      send_pkt(3, 1, 50, 32'h0000_00FF);
      drain();
      check("sb_count", log_tid.size() == 1, 32'(log_tid.size()), 32'd1);
      if (log_tid.size() >= 1) begin
         check("sb_tid", log_tid[0] == 3, 32'(log_tid[0]), 32'd3);
         check("sb_last", log_last[0] == 1, 32'(log_last[0]), 32'd1);
         check("sb_latency", log_cyc[0] - last_s_cyc == 1, 32'(log_cyc[0] - last_s_cyc), 32'd1);
      end
      arb_one(4'b1011, 0, 51);
      drain();

      // Asynchronous reset in the middle of a 5-beat port-0 packet.
      clear_logs();
      fork
         send_pkt(0, 5, 60, '1);
      join_none
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         #1;
         if (hs_cnt[0] >= 2) break;
      end
      @(posedge clk);
      #3;
      check("mr_pre_valid", m_tvalid == 1'b1, 32'(m_tvalid), 32'd1);
      resetn = 1'b0;
      #1;
      check("mr_m_tvalid", m_tvalid == 1'b0, 32'(m_tvalid), 32'd0);
      check("mr_s_tready", s_tready == '0, 32'(s_tready), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      clear_ports();
      resetn = 1'b1;
      clear_logs();
      arb_one(4'b0011, 0, 61);
      drain();
      clear_logs();
      send_pkt(1, 2, 62, '1);
      drain();
      check("mr_count", log_tid.size() == 2, 32'(log_tid.size()), 32'd2);
      for (int i = 0; i < log_tid.size(); i++)
         check("mr_tid", log_tid[i] == 1, 32'(log_tid[i]), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
